decoded_sample_packer: RTL and testbench
========================================

# decoded_sample_packer

Downstream stage of the Huffman decoder. Collects the signed 4-bit symbols the decoder emits on `decodedData`/`tvalid` and packs them LSB-first into 16-bit words. Packed words are buffered in a small FIFO and leave on a valid/ready stream toward memory or the host link. The decoder has no backpressure, so the packer absorbs bursts, flags overflow and counts symbols for debug.

## Interface
Parameters:
- `DATA_W`, 4: symbol width; matches decoder `decodedData`.
- `PACK`, 4: symbols per output word.
- `WORD_W`, `DATA_W*PACK` = 16: output word width.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `tvalid`  in  1  decoder symbol strobe; one symbol per asserted cycle.
- `decodedData`  in  DATA_W  signed symbol; sampled only when `tvalid`=1.
- `flush`  in  1  one-cycle request to emit a partially filled word.
- `mValid`  out  1  FIFO head valid.
- `mData`  out  WORD_W  packed word at FIFO head.
- `mCount`  out  3  valid symbols in `mData`, 1..PACK.
- `mReady`  in  1  sink accepts head when `mValid`&`mReady`.
- `overflow`  out  1  sticky; a word was dropped because the FIFO was full.
- `symCount`  out  16  total symbols accepted since reset; wraps.

## Operation
- Pack register `pk` (WORD_W) plus fill counter `fill` (0..PACK-1).
- On `tvalid`: symbol written to nibble `fill`, bits [4*fill+3 : 4*fill]. `fill` increments. `symCount` increments, wrapping 16'hFFFF -> 0.
- Word complete (`tvalid` while `fill`=PACK-1): push {`pk` with new nibble, count=PACK} to the FIFO. Then `fill`<=0 and `pk`<=0.
- `flush` with `fill`>0 and no `tvalid`: push {`pk`, count=`fill`}. Unused upper nibbles are zero. Clear `fill`/`pk`.
- `flush` together with `tvalid`:
  - The symbol is inserted first.
  - Exactly one push occurs, with count=`fill`+1 (count=PACK if the word completes).
- `flush` with `fill`=0 and no `tvalid`: no push, no effect.
- FIFO full when a push is required and no pop that cycle:
  - The word is dropped and `overflow`<=1.
  - Pack state clears as if the push succeeded.
- Full FIFO with a push and a pop in the same cycle: the push is accepted with no overflow.
- `overflow` clears only on reset.
- `decodedData` sign is preserved bit-exact. No extension happens inside the packed word.

## Timing
- Reset (`reset`=0 at a rising edge):
  - `mValid`=0, `mData`=0, `mCount`=0, `overflow`=0, `symCount`=0.
  - `fill`=0, `pk`=0, FIFO empty.
  - Reset mid-word discards the partial word. Reset takes priority over all inputs.
- Latency: a completing symbol or flush at edge N gives `mValid`=1 with that word after edge N (visible in cycle N+1).
- FIFO is show-ahead: `mData`/`mCount` are registered and stable while `mValid`=1 and `mReady`=0.
- Pop on `mValid`&`mReady`; the next entry appears the following cycle. Back-to-back pops are sustained at 1 word/cycle.
- `mReady` while `mValid`=0 is ignored.
- Sustained throughput of 1 symbol/cycle needs the sink to pop 1 word per PACK cycles.

## Structure
- Shared package `huff_pkg`:
  - `DATA_W`, `PACK`, `WORD_W`, count width.
  - Typedef for the symbol (signed [DATA_W-1:0]) and for the packed-word+count FIFO entry.
  - The decoder uses the same `DATA_W`.
- One sub-module: `packer_fifo`.
  - Synchronous FIFO, width WORD_W+3, depth FIFO_DEPTH.
  - Registered read pointer and output register, `full`/`empty` flags.
  - Simultaneous push+pop when full allowed.
- Top level holds the pack register, fill counter, overflow flag and symbol counter. Target size: ~200 lines.

## Test plan
- Full word: `tvalid` on 4 consecutive cycles with F, 2, 8, 7 (-1, 2, -8, 7) and `mReady`=1 -> next cycle `mValid`=1, `mData`=16'h782F, `mCount`=4; `symCount`=4.
- Partial flush: symbols 3, E, then `flush` alone -> `mData`=16'h00E3, `mCount`=2. A second `flush` with `fill`=0 -> no new word.
- Flush with symbol: symbols 1, 2, then `tvalid`=1 (5) with `flush`=1 -> single word 16'h0521, `mCount`=3. With 3 prior symbols, the same stimulus gives a single word with `mCount`=4 and no extra empty word.
- Overflow: `mReady`=0, push 5 full words 16'h1111..16'h5555 -> `overflow`=1 after the 5th word. Then raise `mReady` -> pops exactly 16'h1111, 16'h2222, 16'h3333, 16'h4444, then `mValid`=0.
- Full FIFO, push+pop same cycle: FIFO holds 4 words, `mReady`=1 on the cycle a 5th word completes -> no overflow. Output order preserved, all 5 words received.
- Reset mid-operation: after 2 symbols and 1 queued word, `reset`=0 for one cycle -> all outputs 0, `mValid`=0. Next 4 symbols A, B, C, D give 16'hDCBA with `symCount`=4.

Source files
------------

// File: rtl/huff_pkg.sv
// huff_pkg: shared widths and types for the Huffman decoder and its sample packer
package huff_pkg;
  localparam int DATA_W = 4;
  localparam int PACK   = 4;
  localparam int WORD_W = DATA_W * PACK;
  localparam int CNT_W  = $clog2(PACK) + 1;
  typedef logic signed [DATA_W-1:0] sym_t;
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
  } entry_t;
endpackage

// File: rtl/decoded_sample_packer_if.sv
// decoded_sample_packer_if: decoder symbol strobe, flush, packed-word stream and debug status
//   tvalid/decodedData/flush : symbol input side (master drives)
//   mValid/mData/mCount/mReady : packed-word stream (mReady from master)
//   overflow/symCount : sticky drop flag and accepted-symbol counter
interface decoded_sample_packer_if;
  import huff_pkg::*;
  logic              tvalid;
  sym_t              decodedData;
  logic              flush;
  logic              mValid;
  logic [WORD_W-1:0] mData;
  logic [CNT_W-1:0]  mCount;
  logic              mReady;
  logic              overflow;
  logic [15:0]       symCount;
  modport slave (input tvalid, decodedData, flush, mReady,
                 output mValid, mData, mCount, overflow, symCount);
  modport master (output tvalid, decodedData, flush, mReady,
                  input mValid, mData, mCount, overflow, symCount);
endinterface

// File: rtl/packer_fifo.sv
// packer_fifo: show-ahead synchronous FIFO of packed words with their symbol counts
//   clk/reset : clock, synchronous active-low reset
//   i_push/i_entry : write request and entry; dropped when full unless popping
//   i_pop : consume head (ignored when empty)
//   o_valid/o_entry : head valid and registered head entry
//   o_full : every slot occupied
module packer_fifo import huff_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_push,
  input  entry_t i_entry,
  input  logic   i_pop,
  output logic   o_valid,
  output entry_t o_entry,
  output logic   o_full
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  entry_t        r_mem [DEPTH];
  logic          w_pop, w_push;
  always_comb begin
    o_valid = r_cnt != '0;
    o_full  = r_cnt == (AW+1)'(DEPTH);
    o_entry = r_mem[r_rd];
    w_pop   = i_pop & o_valid;
    // a pop frees the slot the write lands in, so full+pop still accepts
    w_push  = i_push & (~o_full | w_pop);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_entry;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/decoded_sample_packer.sv
// decoded_sample_packer: packs decoder symbols LSB-first into words and queues them for the sink
//   clk/reset : clock, synchronous active-low reset
//   bus (slave) : symbol input, flush, packed-word stream, overflow and symbol count
module decoded_sample_packer import huff_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  decoded_sample_packer_if.slave bus
);
  localparam int FW = $clog2(PACK);
  logic [FW-1:0]     r_fill;
  logic [WORD_W-1:0] r_pk;
  logic              r_overflow;
  logic [15:0]       r_sym_count;
  logic [WORD_W-1:0] w_pk;
  logic              w_push, w_pop, w_full, w_valid;
  entry_t            w_entry, w_head;
  always_comb begin
    // upper nibbles of r_pk are always zero, so OR-ing in the new nibble is enough;
    // the zero-padded concat keeps the signed symbol from sign-extending
    w_pk    = bus.tvalid ? r_pk | ({{(WORD_W-DATA_W){1'b0}}, bus.decodedData} << (DATA_W * r_fill)) : r_pk;
    w_push  = bus.tvalid ? (r_fill == FW'(PACK-1)) | bus.flush : bus.flush & (r_fill != '0);
    w_entry = '{data: w_pk, cnt: CNT_W'(r_fill) + CNT_W'(bus.tvalid)};
    w_pop   = w_valid & bus.mReady;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fill      <= '0;
      r_pk        <= '0;
      r_overflow  <= 1'b0;
      r_sym_count <= '0;
    end else begin
      if (w_push) begin
        r_fill <= '0;
        r_pk   <= '0;
      end else if (bus.tvalid) begin
        r_fill <= r_fill + 1'b1;
        r_pk   <= w_pk;
      end
      if (bus.tvalid) r_sym_count <= r_sym_count + 16'd1;
      if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
    end
  end
  packer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .i_push (w_push),
    .i_entry(w_entry),
    .i_pop  (w_pop),
    .o_valid(w_valid),
    .o_entry(w_head),
    .o_full (w_full)
  );
  assign bus.mValid   = w_valid;
  assign bus.mData    = w_head.data;
  assign bus.mCount   = w_head.cnt;
  assign bus.overflow = r_overflow;
  assign bus.symCount = r_sym_count;
endmodule

// File: tb/tb_decoded_sample_packer.sv
// tb_decoded_sample_packer: scoreboard bench for the sample packer
module tb_decoded_sample_packer;
  import huff_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  logic [18:0] q[$];
  decoded_sample_packer_if ifc();
  decoded_sample_packer #(.FIFO_DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(ifc));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (reset && ifc.mValid && ifc.mReady) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word act=%h/%0d req=none", ifc.mData, ifc.mCount);
      end else begin
        logic [18:0] e;
        e = q.pop_front();
        if ({ifc.mData, ifc.mCount} !== e) begin
          bad++;
          $display("FAIL word act=%h/%0d req=%h/%0d", ifc.mData, ifc.mCount, e[18:3], e[2:0]);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask
  task automatic exp(input logic [15:0] d, input logic [2:0] c);
    q.push_back({d, c});
  endtask
  task automatic sym(input logic [3:0] d, input logic fl);
    ifc.tvalid = 1'b1;
    ifc.decodedData = d;
    ifc.flush = fl;
    @(posedge clk);
    #1;
    ifc.tvalid = 1'b0;
    ifc.flush = 1'b0;
  endtask
  task automatic flush_only();
    ifc.flush = 1'b1;
    @(posedge clk);
    #1;
    ifc.flush = 1'b0;
  endtask
  task automatic word(input logic [3:0] d);
    for (int i = 0; i < 4; i++) sym(d, 1'b0);
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drain(input string name);
    int t;
    t = 0;
    while (q.size() != 0 && t < 60) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain_timeout act=%0d req=0 left", name, q.size());
      q.delete();
    end
    idle(2);
    chk({name, "_empty"}, 32'(ifc.mValid), 0);
  endtask
  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    chk("rst_mValid", 32'(ifc.mValid), 0);
    chk("rst_mData", 32'(ifc.mData), 0);
    chk("rst_mCount", 32'(ifc.mCount), 0);
    chk("rst_overflow", 32'(ifc.overflow), 0);
    chk("rst_symCount", 32'(ifc.symCount), 0);
    reset = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end
  initial begin
    ifc.tvalid = 1'b0;
    ifc.decodedData = '0;
    ifc.flush = 1'b0;
    ifc.mReady = 1'b0;
    @(posedge clk);
    do_reset();
    ifc.mReady = 1'b1;
    exp(16'h782F, 3'd4);
    sym(4'hF, 0); sym(4'h2, 0); sym(4'h8, 0); sym(4'h7, 0);
    chk("full_symCount", 32'(ifc.symCount), 4);
    chk("full_mValid", 32'(ifc.mValid), 1);
    drain("full");
    exp(16'h00E3, 3'd2);
    sym(4'h3, 0); sym(4'hE, 0); flush_only();
    idle(2);
    flush_only();
    drain("partial");
    exp(16'h0521, 3'd3);
    sym(4'h1, 0); sym(4'h2, 0); sym(4'h5, 1);
    exp(16'h4321, 3'd4);
    sym(4'h1, 0); sym(4'h2, 0); sym(4'h3, 0); sym(4'h4, 1);
    drain("flushsym");
    chk("flushsym_symCount", 32'(ifc.symCount), 13);
    ifc.mReady = 1'b0;
    exp(16'h1111, 3'd4); exp(16'h2222, 3'd4); exp(16'h3333, 3'd4); exp(16'h4444, 3'd4);
    word(4'h1); word(4'h2); word(4'h3); word(4'h4);
    chk("ovf_before", 32'(ifc.overflow), 0);
    word(4'h5);
    chk("ovf_after", 32'(ifc.overflow), 1);
    idle(2);
    chk("ovf_hold_data", 32'(ifc.mData), 32'h1111);
    chk("ovf_hold_cnt", 32'(ifc.mCount), 4);
    ifc.mReady = 1'b1;
    drain("ovf");
    chk("ovf_sticky", 32'(ifc.overflow), 1);
    do_reset();
    ifc.mReady = 1'b0;
    exp(16'h6666, 3'd4); exp(16'h7777, 3'd4); exp(16'h8888, 3'd4); exp(16'h9999, 3'd4);
    exp(16'hAAAA, 3'd4);
    word(4'h6); word(4'h7); word(4'h8); word(4'h9);
    sym(4'hA, 0); sym(4'hA, 0); sym(4'hA, 0);
    ifc.mReady = 1'b1;
    sym(4'hA, 0);
    chk("pushpop_ovf", 32'(ifc.overflow), 0);
    drain("pushpop");
    ifc.mReady = 1'b0;
    word(4'h1);
    sym(4'h5, 0); sym(4'h6, 0);
    chk("midrst_pre_mValid", 32'(ifc.mValid), 1);
    do_reset();
    ifc.mReady = 1'b1;
    exp(16'hDCBA, 3'd4);
    sym(4'hA, 0); sym(4'hB, 0); sym(4'hC, 0); sym(4'hD, 0);
    chk("midrst_symCount", 32'(ifc.symCount), 4);
    drain("midrst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
